// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes used by the write-port arbiter and its scoreboard.
package regfile_pkg;

  localparam int REG_ABITS = 5;
  localparam int REG_DBITS = 32;
  localparam int REG_NLOC  = 32;

  typedef struct packed {
    logic [REG_ABITS-1:0] addr;
    logic [REG_DBITS-1:0] data;
  } reg_wr_t;

  typedef enum logic {PRIO_A, FORCE_B} arb_state_t;

endpackage

// File: rtl/regwr_scoreboard.sv
// Set/clear bit array of registers claimed by the multi-cycle unit but not yet written back.
module regwr_scoreboard #(
  parameter int Abits = 5,
  parameter int Nloc  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             claim,
  input  logic [Abits-1:0] claimAddr,
  input  logic             clear,
  input  logic [Abits-1:0] clearAddr,
  output logic [Nloc-1:0]  pending
);

  logic [Nloc-1:0] setMask;
  logic [Nloc-1:0] clrMask;
  logic [Nloc-1:0] pendingNext;

  // Set is applied after clear so a same-cycle claim of the written register wins
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (claim && (claimAddr != '0) && (int'(claimAddr) < Nloc))
      setMask[claimAddr] = 1'b1;
    if (clear && (int'(clearAddr) < Nloc))
      clrMask[clearAddr] = 1'b1;
    pendingNext    = (pending & ~clrMask) | setMask;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= pendingNext;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (A) and a starvation-protected
// multi-cycle unit (B). Define REGWR_SCOREBOARD_EN to include the pending-destination scoreboard.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int Abits      = REG_ABITS,
  parameter int Dbits      = REG_DBITS,
  parameter int Nloc       = REG_NLOC,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [Abits-1:0] a_addr,
  input  logic [Dbits-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [Abits-1:0] b_addr,
  input  logic [Dbits-1:0] b_data,
  output logic             b_ready,
  input  logic             b_claim,
  input  logic [Abits-1:0] b_claim_addr,
  output logic             wr,
  output logic [Abits-1:0] WriteAddr,
  output logic [Dbits-1:0] WriteData,
  output logic [Nloc-1:0]  pending
);

  arb_state_t       state;
  arb_state_t       stateNext;
  logic [3:0]       starve;
  logic [3:0]       starveNext;
  logic             aGrant;
  logic             bGrant;
  logic             anyGrant;
  logic [Abits-1:0] winAddr;
  logic [Dbits-1:0] winData;
  logic             realWrite;

  assign a_ready   = (state == PRIO_A);
  assign b_ready   = (state == FORCE_B) || !a_valid;
  assign aGrant    = a_valid && a_ready;
  assign bGrant    = b_valid && b_ready;
  assign anyGrant  = aGrant || bGrant;
  assign winAddr   = aGrant ? a_addr : b_addr;
  assign winData   = aGrant ? a_data : b_data;
  assign realWrite = anyGrant && (winAddr != '0);

  // Entering FORCE_B on the same edge the counter saturates bounds B's wait to STARVE_MAX+1 cycles
  always_comb begin
    starveNext = starve;
    stateNext  = state;
    if (!b_valid || bGrant)
      starveNext = '0;
    else if (starve < 4'(STARVE_MAX))
      starveNext = starve + 4'd1;
    case (state)
      PRIO_A:  if (starveNext == 4'(STARVE_MAX)) stateNext = FORCE_B;
      FORCE_B: if (bGrant || !b_valid) stateNext = PRIO_A;
      default: stateNext = PRIO_A;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= PRIO_A;
      starve <= '0;
    end else begin
      state  <= stateNext;
      starve <= starveNext;
    end
  end

  // Register 0 is hardwired to zero, so its writes complete the handshake but never reach the port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr        <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      wr <= realWrite;
      if (realWrite) begin
        WriteAddr <= winAddr;
        WriteData <= winData;
      end
    end
  end

`ifdef REGWR_SCOREBOARD_EN
  regwr_scoreboard #(
    .Abits(Abits),
    .Nloc (Nloc)
  ) scoreboard (
    .clock    (clock),
    .reset    (reset),
    .claim    (b_claim),
    .claimAddr(b_claim_addr),
    .clear    (bGrant),
    .clearAddr(b_addr),
    .pending  (pending)
  );
`else
  logic unusedClaim;
  assign unusedClaim = ^{b_claim, b_claim_addr};
  assign pending     = '0;
`endif

endmodule
